// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Serial program loader in front of the instruction-fetch stage. It receives an
// MCU program image over a UART line (8N1, LSB first, idle high) and writes it
// into program memory one instruction at a time. The pipeline core is held in
// reset until a complete image has been received and its checksum matches.
//
// Image format on the wire:
//   count byte N (0 means 256), then N x {b0, b1, b2}, then one checksum byte.
//   instruction = {b2[0], b1, b0}; b2[7:1] are padding but still enter the
//   checksum. checksum = XOR of all 3N instruction bytes (count excluded).
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-low reset
//   uart_rx     asynchronous serial input, idle high
//   load_req    one-cycle pulse; restarts loading from DONE or ERROR
//   prog_we     program-memory write strobe, one cycle per instruction
//   prog_addr   program-memory write address
//   prog_wdata  program-memory write data
//   cpu_reset   active-low reset to the core; high only in DONE
//   loading     high while an image is being received
//   done        high once a verified image is in memory
//   frame_err   sticky; a byte with a bad stop bit was seen
//   chk_err     sticky; checksum byte did not match
//
// The instruction packing ({b2[0], b1, b0}) fixes INST_W at 17.
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8,
  parameter int INST_W       = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  input  logic              load_req,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [INST_W-1:0] prog_wdata,
  output logic              cpu_reset,
  output logic              loading,
  output logic              done,
  output logic              frame_err,
  output logic              chk_err
);

  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  rx_state_e        rx_state_q;
  logic [1:0]       sync_q;
  logic             rx_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             byte_valid_q;   // one-cycle pulse, shift_q holds the byte
  logic             stop_err_q;     // one-cycle pulse, stop bit sampled as 0

  logic rx_line;
  assign rx_line = sync_q[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the synchroniser resets to the idle line level (1) so that
      // leaving reset never looks like a falling start edge.
      sync_q       <= 2'b11;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      stop_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere in clocked logic, so every
      // register here sees the previous-cycle value of every other one.
      sync_q       <= {sync_q[0], uart_rx};
      rx_prev_q    <= rx_line;
      byte_valid_q <= 1'b0;
      stop_err_q   <= 1'b0;

      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_line) begin
            rx_state_q <= RX_START;
            cnt_q      <= '0;
          end
        end

        // Re-check the line half a bit after the edge; short glitches are
        // rejected here and never reach the byte assembler.
        RX_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            if (rx_line) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_state_q <= RX_DATA;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // From here every sample lands one full bit period later, i.e. near
        // the middle of each bit.
        RX_DATA: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q   <= '0;
            shift_q <= {rx_line, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        RX_STOP: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q        <= '0;
            rx_state_q   <= RX_IDLE;
            byte_valid_q <= rx_line;
            stop_err_q   <= !rx_line;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    LD_RX_COUNT,
    LD_RX_B0,
    LD_RX_B1,
    LD_RX_B2,
    LD_RX_CHK,
    LD_DONE,
    LD_ERROR
  } ld_state_e;

  ld_state_e         ld_state_q;
  logic [ADDR_W-1:0] n_last_q;      // address of the final instruction
  logic [7:0]        checksum_q;
  logic              prog_we_q;
  logic [ADDR_W-1:0] prog_addr_q;
  logic [INST_W-1:0] prog_wdata_q;
  logic              cpu_reset_q;
  logic              loading_q;
  logic              done_q;
  logic              frame_err_q;
  logic              chk_err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      // Program memory lives outside this block; a reset only aborts the
      // transfer and leaves already-written instructions in place.
      ld_state_q   <= LD_RX_COUNT;
      n_last_q     <= '0;
      checksum_q   <= '0;
      prog_we_q    <= 1'b0;
      prog_addr_q  <= '0;
      prog_wdata_q <= '0;
      cpu_reset_q  <= 1'b0;
      loading_q    <= 1'b1;
      done_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      chk_err_q    <= 1'b0;
    end else begin
      // The write strobe lasts one cycle; the address advances right after
      // it. For N=256 this last increment wraps the address back to 0.
      if (prog_we_q) begin
        prog_we_q   <= 1'b0;
        prog_addr_q <= prog_addr_q + 1'b1;
      end

      if (loading_q && stop_err_q) begin
        // A broken byte makes the rest of the image untrustworthy.
        ld_state_q  <= LD_ERROR;
        frame_err_q <= 1'b1;
        loading_q   <= 1'b0;
        cpu_reset_q <= 1'b0;
      end else begin
        case (ld_state_q)
          LD_RX_COUNT: begin
            if (byte_valid_q) begin
              // Subtracting in 8 bits maps a count of 0 to a last address of
              // 255, which is exactly the "0 means 256" rule.
              n_last_q    <= ADDR_W'(shift_q - 8'd1);
              prog_addr_q <= '0;
              checksum_q  <= '0;
              ld_state_q  <= LD_RX_B0;
            end
          end

          LD_RX_B0: begin
            if (byte_valid_q) begin
              prog_wdata_q[7:0] <= shift_q;
              checksum_q        <= checksum_q ^ shift_q;
              ld_state_q        <= LD_RX_B1;
            end
          end

          LD_RX_B1: begin
            if (byte_valid_q) begin
              prog_wdata_q[15:8] <= shift_q;
              checksum_q         <= checksum_q ^ shift_q;
              ld_state_q         <= LD_RX_B2;
            end
          end

          LD_RX_B2: begin
            if (byte_valid_q) begin
              prog_wdata_q[16] <= shift_q[0];
              checksum_q       <= checksum_q ^ shift_q;
              prog_we_q        <= 1'b1;
              // prog_addr_q still holds the address being written here.
              if (prog_addr_q == n_last_q) begin
                ld_state_q <= LD_RX_CHK;
              end else begin
                ld_state_q <= LD_RX_B0;
              end
            end
          end

          LD_RX_CHK: begin
            if (byte_valid_q) begin
              loading_q <= 1'b0;
              if (shift_q == checksum_q) begin
                ld_state_q  <= LD_DONE;
                cpu_reset_q <= 1'b1;
                done_q      <= 1'b1;
              end else begin
                ld_state_q <= LD_ERROR;
                chk_err_q  <= 1'b1;
              end
            end
          end

          // DONE and ERROR ignore the serial line and wait for a restart.
          LD_DONE, LD_ERROR: begin
            if (load_req) begin
              ld_state_q  <= LD_RX_COUNT;
              frame_err_q <= 1'b0;
              chk_err_q   <= 1'b0;
              checksum_q  <= '0;
              prog_addr_q <= '0;
              cpu_reset_q <= 1'b0;
              done_q      <= 1'b0;
              loading_q   <= 1'b1;
            end
          end

          default: ld_state_q <= LD_RX_COUNT;
        endcase
      end
    end
  end

  assign prog_we    = prog_we_q;
  assign prog_addr  = prog_addr_q;
  assign prog_wdata = prog_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign loading    = loading_q;
  assign done       = done_q;
  assign frame_err  = frame_err_q;
  assign chk_err    = chk_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Self-checking bench for prog_loader with CLKS_PER_BIT=4. Images are built
// from random instructions; the expected memory writes and final status are
// derived directly from the image contents.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  localparam int CPB    = 4;
  localparam int ADDR_W = 8;
  localparam int INST_W = 17;

  logic              clk = 1'b0;
  logic              reset;
  logic              uart_rx;
  logic              load_req;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [INST_W-1:0] prog_wdata;
  logic              cpu_reset;
  logic              loading;
  logic              done;
  logic              frame_err;
  logic              chk_err;

  prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (ADDR_W),
    .INST_W      (INST_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .load_req  (load_req),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_wdata(prog_wdata),
    .cpu_reset (cpu_reset),
    .loading   (loading),
    .done      (done),
    .frame_err (frame_err),
    .chk_err   (chk_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [INST_W-1:0] insts [256];
  logic [ADDR_W+INST_W-1:0] wq [$];   // observed writes {addr, data}

  always @(negedge clk) begin
    if (prog_we) wq.push_back({prog_addr, prog_wdata});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tx_bit(input logic v);
    @(negedge clk);
    uart_rx = v;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(b[i]);
    tx_bit(stop_bit);
    @(negedge clk);
    uart_rx = 1'b1;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  // Sends a full image of n instructions from insts[]. The transmitted
  // checksum is the true XOR of the instruction bytes XORed with chk_xor.
  task automatic send_frame(input int n, input bit rand_pad, input logic [7:0] chk_xor);
    logic [7:0] chk;
    logic [7:0] b2;
    chk = 8'h00;
    send_byte((n == 256) ? 8'h00 : 8'(n), 1'b1);
    for (int i = 0; i < n; i++) begin
      b2  = {(rand_pad ? 7'($urandom) : 7'h00), insts[i][16]};
      chk = chk ^ insts[i][7:0] ^ insts[i][15:8] ^ b2;
      send_byte(insts[i][7:0], 1'b1);
      send_byte(insts[i][15:8], 1'b1);
      send_byte(b2, 1'b1);
    end
    send_byte(chk ^ chk_xor, 1'b1);
  endtask

  task automatic wait_status(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done || chk_err || frame_err) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_finished"}, 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input int n);
    check({tag, "_nwrites"}, 32'(wq.size()), 32'(n));
    for (int i = 0; i < n && i < wq.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(wq[i][ADDR_W+INST_W-1:INST_W]), 32'(i % 256));
      check($sformatf("%s_data%0d", tag, i), 32'(wq[i][INST_W-1:0]), 32'(insts[i]));
    end
  endtask

  task automatic check_status(input string tag, input bit exp_done, input bit exp_chk,
                              input bit exp_frm);
    check({tag, "_done"},      32'(done),      32'(exp_done));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(exp_done));
    check({tag, "_chk_err"},   32'(chk_err),   32'(exp_chk));
    check({tag, "_frame_err"}, 32'(frame_err), 32'(exp_frm));
    check({tag, "_loading"},   32'(loading),   32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_prog_we"},    32'(prog_we),    32'd0);
    check({tag, "_prog_addr"},  32'(prog_addr),  32'd0);
    check({tag, "_prog_wdata"}, 32'(prog_wdata), 32'd0);
    check({tag, "_cpu_reset"},  32'(cpu_reset),  32'd0);
    check({tag, "_loading"},    32'(loading),    32'd1);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_frame_err"},  32'(frame_err),  32'd0);
    check({tag, "_chk_err"},    32'(chk_err),    32'd0);
  endtask

  task automatic pulse_load_req(input string tag);
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check({tag, "_loading"},   32'(loading),   32'd1);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_chk_err"},   32'(chk_err),   32'd0);
    check({tag, "_prog_addr"}, 32'(prog_addr), 32'd0);
    wq.delete();
  endtask

  initial begin
    int n;
    int nw;
    logic [7:0] x;

    reset    = 1'b0;
    uart_rx  = 1'b1;
    load_req = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Directed image: checksum 0xD8 is correct.
    insts[0] = 17'h11234;
    insts[1] = 17'h000FF;
    wq.delete();
    send_frame(2, 1'b0, 8'h00);
    wait_status("dir");
    check_writes("dir", 2);
    check_status("dir", 1'b1, 1'b0, 1'b0);
    check("dir_addr_after", 32'(prog_addr), 32'd2);

    // Bytes received in DONE are ignored.
    nw = wq.size();
    send_byte(8'h03, 1'b1);
    repeat (10) @(negedge clk);
    check("done_ignore_nwrites", 32'(wq.size()), 32'(nw));
    check("done_ignore_done", 32'(done), 32'd1);

    // Same image with checksum 0x00.
    pulse_load_req("rl_done");
    send_frame(2, 1'b0, 8'hD8);
    wait_status("badchk");
    check_writes("badchk", 2);
    check_status("badchk", 1'b0, 1'b1, 1'b0);
    pulse_load_req("rl_chk");

    // Bad stop bit on the second byte.
    send_byte(8'h02, 1'b1);
    send_byte(8'h34, 1'b0);
    wait_status("frm");
    check("frm_nwrites", 32'(wq.size()), 32'd0);
    check_status("frm", 1'b0, 1'b0, 1'b1);
    pulse_load_req("rl_frm");

    // One-cycle glitch, then a normal random image.
    @(negedge clk);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_loading", 32'(loading), 32'd1);
    n = $urandom_range(1, 8);
    for (int i = 0; i < n; i++) insts[i] = 17'($urandom);
    send_frame(n, 1'b1, 8'h00);
    wait_status("glitch");
    check_writes("glitch", n);
    check_status("glitch", 1'b1, 1'b0, 1'b0);

    // Random images, some with corrupted checksums.
    for (int t = 0; t < 4; t++) begin
      pulse_load_req($sformatf("rl_rnd%0d", t));
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) insts[i] = 17'($urandom);
      x = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame(n, 1'b1, x);
      wait_status($sformatf("rnd%0d", t));
      check_writes($sformatf("rnd%0d", t), n);
      check_status($sformatf("rnd%0d", t), x == 8'h00, x != 8'h00, 1'b0);
    end

    // Count byte 0 means 256 instructions; address wraps to 0 afterwards.
    pulse_load_req("rl_256");
    for (int i = 0; i < 256; i++) insts[i] = 17'(i);
    send_frame(256, 1'b0, 8'h00);
    wait_status("n256");
    check_writes("n256", 256);
    check_status("n256", 1'b1, 1'b0, 1'b0);
    check("n256_addr_wrap", 32'(prog_addr), 32'd0);

    // Reset after B1 of instruction 0, then a fresh image.
    pulse_load_req("rl_mid");
    send_byte(8'h03, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("midrst");
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_nwrites", 32'(wq.size()), 32'd0);
    n = $urandom_range(2, 6);
    for (int i = 0; i < n; i++) insts[i] = 17'($urandom);
    send_frame(n, 1'b1, 8'h00);
    wait_status("fresh");
    check_writes("fresh", n);
    check_status("fresh", 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
